mem_sp_ram_ctrl: RTL

Parametrised single-port synchronous RAM with a request/valid front end. It is the next-generation replacement for the fixed 32x64 RAM.
- Adds byte-lane write enables, a configurable read latency and an optional output register.
- Adds a hardware clear engine that zeroes the array after reset or on command.
- Sits between the memory controller (mc_* signals) and the datapath, one instance per memory bank.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_sp_ram_core.sv | 33 +++
 rtl/mem_sp_ram_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the single-port RAM controller: FSM encoding and
// read-latency constants.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam int RD_LAT_BASE = 1;

    function automatic int rd_lat(input int out_reg);
        return RD_LAT_BASE + out_reg;
    endfunction

endpackage

// File: rtl/mem_sp_ram_core.sv
// Byte-enabled single-port array with a registered read address, written so
// that synthesis maps it onto block RAM.
module mem_sp_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] addr_p0;

    // Stage p0: array write and read-address capture
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) ram[addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
        addr_p0 <= addr;
    end

    assign dout = ram[addr_p0];

endmodule

// File: rtl/mem_sp_ram_ctrl.sv
// Request/valid front end for one memory bank: clear engine, address range
// check and read-valid pipeline around mem_sp_ram_core.
module mem_sp_ram_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 6,
    parameter int DEPTH          = 64,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                mem_clk,
    input  logic                mem_rst_n,
    input  logic                mc_req,
    input  logic                mc_we,
    input  logic [ADDR_W-1:0]   mc_address_mem,
    input  logic [DATA_W/8-1:0] mc_be,
    input  logic [DATA_W-1:0]   mem_data_in,
    input  logic                mc_clear,
    output logic                mem_ready,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_data_out,
    output logic                mem_init_done
);

    localparam int               NB      = DATA_W / 8;
    localparam int               RD_LAT  = rd_lat(OUT_REG);
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam mem_state_e       RST_ST  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    mem_state_e        state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              ready_q, init_done_q, init_done_nxt;
    logic              rd_acc, wr_acc, in_range;
    logic              core_we;
    logic [NB-1:0]     core_be;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_din, core_dout, rd_data_p1;
    logic              vld_p1, oor_p1;

    assign in_range = {1'b0, mc_address_mem} < DEPTH_C;
    assign wr_acc   = mc_req && mc_we && ready_q;
    assign rd_acc   = mc_req && !mc_we && ready_q;

    // The clear engine owns the array port while in CLEAR; otherwise the
    // requester drives it and out-of-range writes are suppressed.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        init_done_nxt = init_done_q;
        core_we       = 1'b0;
        core_be       = mc_be;
        core_addr     = mc_address_mem;
        core_din      = mem_data_in;
        case (state)
            ST_CLEAR: begin
                core_we   = 1'b1;
                core_be   = '1;
                core_addr = cnt[ADDR_W-1:0];
                core_din  = '0;
                if (cnt == LAST_C) begin
                    state_nxt     = ST_READY;
                    cnt_nxt       = '0;
                    init_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                core_we       = wr_acc && in_range;
                init_done_nxt = 1'b1;
                if (mc_clear) state_nxt = ST_CLEAR;
            end
            default: state_nxt = ST_READY;
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state       <= RST_ST;
            cnt         <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            vld_p1      <= 1'b0;
            oor_p1      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ready_q     <= (state_nxt == ST_READY);
            init_done_q <= init_done_nxt;
            vld_p1      <= rd_acc;
            oor_p1      <= rd_acc && !in_range;
        end
    end

    mem_sp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk  (mem_clk),
        .we   (core_we),
        .be   (core_be),
        .addr (core_addr),
        .din  (core_din),
        .dout (core_dout)
    );

    // Stage p1: array output, forced to zero for out-of-range reads
    assign rd_data_p1 = oor_p1 ? '0 : core_dout;

    generate
        if (RD_LAT == 2) begin : g_oreg
            logic              vld_p2;
            logic [DATA_W-1:0] data_p2;

            // Stage p2: optional output register, also holds the last read
            always_ff @(posedge mem_clk or negedge mem_rst_n) begin
                if (!mem_rst_n) begin
                    vld_p2  <= 1'b0;
                    data_p2 <= '0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) data_p2 <= rd_data_p1;
                end
            end

            assign mem_rvalid   = vld_p2;
            assign mem_data_out = data_p2;
        end else begin : g_direct
            logic [DATA_W-1:0] hold_p1;

            always_ff @(posedge mem_clk or negedge mem_rst_n) begin
                if (!mem_rst_n) hold_p1 <= '0;
                else if (vld_p1) hold_p1 <= rd_data_p1;
            end

            assign mem_rvalid   = vld_p1;
            assign mem_data_out = vld_p1 ? rd_data_p1 : hold_p1;
        end
    endgenerate

    assign mem_ready     = ready_q;
    assign mem_init_done = init_done_q;

endmodule
